// File: rtl/johnson_run_ctrl.sv
// johnson_run_ctrl
// Run/step sequencer for a WIDTH-bit Johnson counter. It issues clear,
// advance and direction to the counter from start/stop/step commands, paces
// advances with a prescaler, counts full Johnson laps (2*WIDTH advances), and
// stops after a programmed lap count or runs continuously (laps = 0).
//
// Optional feature macro: JC_CHECK_EN
//   When defined, the counter state jc_q is checked against the legal Johnson
//   set while running or stepping. An illegal state sets a sticky jc_err,
//   pulses jc_clr and aborts to IDLE. When undefined, jc_q is ignored and
//   jc_err stays 0.
module johnson_run_ctrl #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4,
  parameter int LAP_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_start,
  input  logic                  cmd_stop,
  input  logic                  cmd_step,
  input  logic                  dir_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [LAP_W-1:0]      laps,
  input  logic [WIDTH-1:0]      jc_q,
  output logic                  jc_clr,
  output logic                  jc_en,
  output logic                  jc_dir,
  output logic                  busy,
  output logic                  done,
  output logic [LAP_W-1:0]      lap_cnt,
  output logic [1:0]            state,
  output logic                  jc_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // adv_cnt counts advances inside one lap: 0 .. 2*WIDTH-1
  localparam int ADV_W = $clog2(2 * WIDTH);
  localparam logic [ADV_W-1:0] ADV_LAST = ADV_W'(2 * WIDTH - 1);

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [PRESCALE_W-1:0] prescale_l_q, prescale_l_d;
  logic [LAP_W-1:0]      laps_l_q, laps_l_d;
  logic [ADV_W-1:0]      adv_cnt_q, adv_cnt_d;
  logic [LAP_W-1:0]      lap_cnt_q, lap_cnt_d;
  logic                  jc_clr_q, jc_clr_d;
  logic                  jc_en_q, jc_en_d;
  logic                  jc_dir_q, jc_dir_d;
  logic                  done_q, done_d;
  logic                  jc_err_q, jc_err_d;

  // Shared effect of one advance on the lap bookkeeping
  logic                  adv_wrap;
  logic [ADV_W-1:0]      adv_next;
  logic [LAP_W-1:0]      lap_next;

  // High when the counter state must be treated as corrupt this cycle
  logic                  jc_bad;

`ifdef JC_CHECK_EN
  // Legal Johnson states are runs of ones from the LSB (2^n-1) and their complements
  function automatic logic jc_legal(input logic [WIDTH-1:0] v);
    logic                   ok;
    logic [WIDTH-1:0]       pat;
    logic [WIDTH-1:0]       ones;
    ok   = 1'b0;
    ones = '1;
    for (int n = 0; n <= WIDTH; n++) begin
      pat = ~(ones << n);
      if ((v == pat) || (v == ~pat)) begin
        ok = 1'b1;
      end
    end
    return ok;
  endfunction

  assign jc_bad = ~jc_legal(jc_q);
`else
  logic jc_q_unused;
  assign jc_q_unused = ^jc_q;
  assign jc_bad      = 1'b0;
`endif

  assign adv_wrap = (adv_cnt_q == ADV_LAST);
  assign adv_next = adv_wrap ? '0 : adv_cnt_q + 1'b1;
  assign lap_next = adv_wrap ? lap_cnt_q + 1'b1 : lap_cnt_q;

  // State register and all registered outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pre_cnt_q    <= '0;
      prescale_l_q <= '0;
      laps_l_q     <= '0;
      adv_cnt_q    <= '0;
      lap_cnt_q    <= '0;
      jc_clr_q     <= 1'b0;
      jc_en_q      <= 1'b0;
      jc_dir_q     <= 1'b0;
      done_q       <= 1'b0;
      jc_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      prescale_l_q <= prescale_l_d;
      laps_l_q     <= laps_l_d;
      adv_cnt_q    <= adv_cnt_d;
      lap_cnt_q    <= lap_cnt_d;
      jc_clr_q     <= jc_clr_d;
      jc_en_q      <= jc_en_d;
      jc_dir_q     <= jc_dir_d;
      done_q       <= done_d;
      jc_err_q     <= jc_err_d;
    end
  end

  // Next-state and next-output logic; pulses default low, everything else holds
  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    prescale_l_d = prescale_l_q;
    laps_l_d     = laps_l_q;
    adv_cnt_d    = adv_cnt_q;
    lap_cnt_d    = lap_cnt_q;
    jc_clr_d     = 1'b0;
    jc_en_d      = 1'b0;
    jc_dir_d     = jc_dir_q;
    done_d       = 1'b0;
    jc_err_d     = jc_err_q;

    if (jc_bad && ((state_q == ST_RUN) || (state_q == ST_STEP))) begin
      jc_err_d = 1'b1;
      jc_clr_d = 1'b1;
      state_d  = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_stop) begin
            state_d = ST_IDLE;
          end else if (cmd_start) begin
            prescale_l_d = prescale;
            laps_l_d     = laps;
            jc_dir_d     = dir_in;
            pre_cnt_d    = '0;
            adv_cnt_d    = '0;
            lap_cnt_d    = '0;
            jc_err_d     = 1'b0;
            jc_clr_d     = 1'b1;
            state_d      = ST_RUN;
          end else if (cmd_step) begin
            jc_dir_d  = dir_in;
            jc_en_d   = 1'b1;
            adv_cnt_d = adv_next;
            lap_cnt_d = lap_next;
            state_d   = ST_STEP;
          end
        end
        ST_RUN: begin
          if (cmd_stop) begin
            state_d = ST_IDLE;
          end else if (pre_cnt_q == prescale_l_q) begin
            jc_en_d   = 1'b1;
            pre_cnt_d = '0;
            adv_cnt_d = adv_next;
            lap_cnt_d = lap_next;
            if (adv_wrap && (laps_l_q != '0) && (lap_next == laps_l_q)) begin
              state_d = ST_DONE;
            end
          end else begin
            pre_cnt_d = pre_cnt_q + 1'b1;
          end
        end
        ST_STEP: begin
          state_d = ST_IDLE;
        end
        ST_DONE: begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign jc_clr  = jc_clr_q;
  assign jc_en   = jc_en_q;
  assign jc_dir  = jc_dir_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign lap_cnt = lap_cnt_q;
  assign state   = state_q;
  assign jc_err  = jc_err_q;

endmodule

// File: tb/tb_johnson_run_ctrl.sv
// tb_johnson_run_ctrl
// Self-checking bench for johnson_run_ctrl (WIDTH=4). A Johnson counter model
// is driven from jc_clr/jc_en/jc_dir and feeds jc_q back. Expected pulse
// timing, lap counts and counter positions are computed arithmetically.
// Test 6 behaviour depends on whether JC_CHECK_EN is defined.
module tb_johnson_run_ctrl;

  localparam int W      = 4;
  localparam int LAPLEN = 2 * W;
  localparam int LAPMOD = 16;

  logic       clk;
  logic       rst;
  logic       cmd_start;
  logic       cmd_stop;
  logic       cmd_step;
  logic       dir_in;
  logic [3:0] prescale;
  logic [3:0] laps;
  logic [3:0] jc_q;
  logic       jc_clr;
  logic       jc_en;
  logic       jc_dir;
  logic       busy;
  logic       done;
  logic [3:0] lap_cnt;
  logic [1:0] state;
  logic       jc_err;

  logic [3:0] jcModel;
  logic       forceBad;

  int tests;
  int fails;
  int expAdv;
  int expPos;

  johnson_run_ctrl #(.WIDTH(4), .PRESCALE_W(4), .LAP_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_start(cmd_start),
    .cmd_stop (cmd_stop),
    .cmd_step (cmd_step),
    .dir_in   (dir_in),
    .prescale (prescale),
    .laps     (laps),
    .jc_q     (jc_q),
    .jc_clr   (jc_clr),
    .jc_en    (jc_en),
    .jc_dir   (jc_dir),
    .busy     (busy),
    .done     (done),
    .lap_cnt  (lap_cnt),
    .state    (state),
    .jc_err   (jc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Johnson counter model: clear, else shift left/right with inverted feedback
  always @(posedge clk) begin
    if (rst || jc_clr) begin
      jcModel <= 4'b0000;
    end else if (jc_en) begin
      if (jc_dir) jcModel <= {~jcModel[0], jcModel[3:1]};
      else        jcModel <= {jcModel[2:0], ~jcModel[3]};
    end
  end

  assign jc_q = forceBad ? 4'b0101 : jcModel;

  // Counter value after n left advances from zero (right advances walk backwards)
  function automatic logic [3:0] johnsonAt(input int n);
    if (n <= W) return 4'((1 << n) - 1);
    return 4'((15 << (n - W)) & 15);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic stop, input logic step,
                               input logic dir, input logic [3:0] pre, input logic [3:0] lp);
    cmd_start = start;
    cmd_stop  = stop;
    cmd_step  = step;
    dir_in    = dir;
    prescale  = pre;
    laps      = lp;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_clr"},   32'(jc_clr),  0);
    checkOutput({tag, "_en"},    32'(jc_en),   0);
    checkOutput({tag, "_dir"},   32'(jc_dir),  0);
    checkOutput({tag, "_busy"},  32'(busy),    0);
    checkOutput({tag, "_done"},  32'(done),    0);
    checkOutput({tag, "_lap"},   32'(lap_cnt), 0);
    checkOutput({tag, "_state"}, 32'(state),   0);
    checkOutput({tag, "_err"},   32'(jc_err),  0);
  endtask

  // Run with prescale P; L laps to completion, or (L=0) stop after nStop advances
  task automatic runSeq(input int P, input int L, input logic dir, input int nStop);
    int total;
    int n;
    int t;
    logic expEn;
    total = (L != 0) ? LAPLEN * L : nStop;
    applyStimulus(1'b1, 1'b0, 1'b0, dir, 4'(P), 4'(L));
    tick;
    checkOutput("start_clr",   32'(jc_clr),  1);
    checkOutput("start_state", 32'(state),   1);
    checkOutput("start_en",    32'(jc_en),   0);
    checkOutput("start_dir",   32'(jc_dir),  32'(dir));
    checkOutput("start_lap",   32'(lap_cnt), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, ~dir, 4'((P + 1) % 16), 4'(L + 1));
    n = 0;
    t = 0;
    while (n < total) begin
      tick;
      t++;
      expEn = ((t % (P + 1)) == 0);
      if (expEn) n++;
      checkOutput("run_en",    32'(jc_en),   32'(expEn));
      checkOutput("run_clr",   32'(jc_clr),  0);
      checkOutput("run_dir",   32'(jc_dir),  32'(dir));
      checkOutput("run_lap",   32'(lap_cnt), 32'((n / LAPLEN) % LAPMOD));
      checkOutput("run_state", 32'(state),   (L != 0 && n == total) ? 3 : 1);
    end
    if (L == 0) cmd_stop = 1'b1;
    tick;
    cmd_stop = 1'b0;
    checkOutput("end_done",  32'(done),    (L != 0) ? 1 : 0);
    checkOutput("end_en",    32'(jc_en),   0);
    checkOutput("end_state", 32'(state),   0);
    checkOutput("end_busy",  32'(busy),    0);
    checkOutput("end_lap",   32'(lap_cnt), 32'((total / LAPLEN) % LAPMOD));
    expAdv = total;
    expPos = dir ? ((LAPLEN - (total % LAPLEN)) % LAPLEN) : (total % LAPLEN);
    checkOutput("end_jcq",   32'(jc_q),    32'(johnsonAt(expPos)));
    for (int k = 0; k < P + 2; k++) begin
      tick;
      checkOutput("idle_en",   32'(jc_en), 0);
      checkOutput("idle_done", 32'(done),  0);
    end
  endtask

  // Single step from IDLE in the given direction
  task automatic doStep(input logic dir);
    applyStimulus(1'b0, 1'b0, 1'b1, dir, 4'd0, 4'd0);
    tick;
    cmd_step = 1'b0;
    expAdv++;
    expPos = dir ? ((expPos + LAPLEN - 1) % LAPLEN) : ((expPos + 1) % LAPLEN);
    checkOutput("step_en",    32'(jc_en),   1);
    checkOutput("step_state", 32'(state),   2);
    checkOutput("step_busy",  32'(busy),    1);
    checkOutput("step_dir",   32'(jc_dir),  32'(dir));
    checkOutput("step_clr",   32'(jc_clr),  0);
    checkOutput("step_lap",   32'(lap_cnt), 32'((expAdv / LAPLEN) % LAPMOD));
    tick;
    checkOutput("step_idle",  32'(state),   0);
    checkOutput("step_en_lo", 32'(jc_en),   0);
    checkOutput("step_clr2",  32'(jc_clr),  0);
    checkOutput("step_jcq",   32'(jc_q),    32'(johnsonAt(expPos)));
  endtask

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Directed sequence followed by randomized runs and steps
  initial begin
    tests    = 0;
    fails    = 0;
    expAdv   = 0;
    expPos   = 0;
    forceBad = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

    // 1. reset, then a lone stop in IDLE
    rst = 1'b1;
    tick;
    tick;
    checkAllZero("reset");
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    tick;
    cmd_stop = 1'b0;
    checkOutput("stop_idle_state", 32'(state),  0);
    checkOutput("stop_idle_clr",   32'(jc_clr), 0);
    checkOutput("stop_idle_busy",  32'(busy),   0);

    // 2. prescale 0, one lap, left
    runSeq(0, 1, 1'b0, 0);

    // 3. prescale 2, continuous, stop after 16 advances
    runSeq(2, 0, 1'b0, 16);

    // 4. three right steps
    doStep(1'b1);
    doStep(1'b1);
    doStep(1'b1);

    // 5. start+stop together, then reset mid-run
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 4'd0);
    tick;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    checkOutput("startstop_state", 32'(state),  0);
    checkOutput("startstop_clr",   32'(jc_clr), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0);
    tick;
    cmd_start = 1'b0;
    tick;
    tick;
    tick;
    checkOutput("midrun_state", 32'(state), 1);
    rst = 1'b1;
    tick;
    checkAllZero("midrun_rst");
    rst    = 1'b0;
    expAdv = 0;
    expPos = 0;

    // 6. illegal counter state during RUN
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd0);
    tick;
    cmd_start = 1'b0;
    tick;
    forceBad = 1'b1;
    tick;
    forceBad = 1'b0;
`ifdef JC_CHECK_EN
    checkOutput("chk_err",   32'(jc_err), 1);
    checkOutput("chk_clr",   32'(jc_clr), 1);
    checkOutput("chk_state", 32'(state),  0);
    checkOutput("chk_en",    32'(jc_en),  0);
    tick;
    checkOutput("chk_sticky", 32'(jc_err), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd0);
    tick;
    cmd_start = 1'b0;
    checkOutput("chk_restart_err",   32'(jc_err), 0);
    checkOutput("chk_restart_state", 32'(state),  1);
`else
    checkOutput("nochk_err",   32'(jc_err), 0);
    checkOutput("nochk_state", 32'(state),  1);
    checkOutput("nochk_clr",   32'(jc_clr), 0);
`endif
    cmd_stop = 1'b1;
    tick;
    cmd_stop = 1'b0;
    checkOutput("chk_stop_state", 32'(state), 0);
    tick;
    expAdv = 0;
    expPos = 0;

    // Randomized mix of lap runs, stopped runs and steps
    for (int it = 0; it < 8; it++) begin
      case ($urandom_range(0, 2))
        0: runSeq(int'($urandom_range(0, 3)), int'($urandom_range(1, 2)),
                  1'($urandom_range(0, 1)), 0);
        1: runSeq(int'($urandom_range(0, 3)), 0,
                  1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
        default: begin
          for (int s = 0; s < int'($urandom_range(1, 4)); s++) begin
            doStep(1'($urandom_range(0, 1)));
          end
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
